operand_stager: RTL and testbench

Parametrised N-lane operand staging buffer that feeds the west edge of the systolic array. It generalises the fixed two-lane input loading path: host words are written to an addressed lane FIFO, and on start the lanes are released as a diagonal wavefront, with lane i delayed i cycles. Optionally, activation outputs are written back into the lanes so the next layer runs without host reloads.

---
 rtl/stager_pkg.sv | 8 +
 rtl/stager_lane_fifo.sv | 63 ++++++
 rtl/operand_stager.sv | 144 ++++++++++++++
 tb/tb_operand_stager.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stager_pkg.sv
// Shared types for the operand staging buffer: FSM state encoding and err bit positions.
package stager_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_COL = 2;
endpackage

// File: rtl/stager_lane_fifo.sv
// One staging lane: DEPTH-entry FIFO with occupancy count and a registered, zeroed-when-idle output.
module stager_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);
    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [AW-1:0]            rd_q, wr_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pop_ok, push_ok;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees a slot, so a full lane can still accept.
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);
    assign ovf_o   = push_i && !push_ok;
    assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            vld_o  <= 1'b0;
            data_o <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) wr_q <= wrap_inc(wr_q);
            if (pop_ok) begin
                rd_q   <= wrap_inc(rd_q);
                vld_o  <= 1'b1;
                data_o <= mem_q[rd_q];
            end else begin
                vld_o  <= 1'b0;
                data_o <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data_i;
    end
endmodule

// File: rtl/operand_stager.sv
// N-lane operand staging buffer releasing lanes as a diagonal wavefront into the systolic array.
// Define OPERAND_STAGER_FEEDBACK_EN to build the activation writeback path and collision check.
module operand_stager
    import stager_pkg::*;
#(
    parameter int N      = 2,
    parameter int DEPTH  = 4,
    parameter int DW     = 16,
    localparam int LW    = (N > 1) ? $clog2(N) : 1,
    localparam int LENW  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    input  logic [LW-1:0]        load_lane,
    input  logic signed [DW-1:0] load_data,
    input  logic [N-1:0]         fb_valid,
    input  logic [N*DW-1:0]      fb_data,
    input  logic                 start,
    input  logic [LENW-1:0]      len,
    output logic [N-1:0]         out_valid,
    output logic [N*DW-1:0]      out_data,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           err
);
    localparam int CW = $clog2(N + (1 << LENW)) + 1;

    state_e                 state_q;
    logic [CW-1:0]          cyc_q, c_sel, len_sel;
    logic [LENW-1:0]        len_q;
    logic [2:0]             err_q, err_set;
    logic [N-1:0]           push, pop, ovf, lane_short, unused_full, unused_empty;
    logic [N-1:0][DW-1:0]   push_data, lane_data;
    logic [N-1:0][LENW-1:0] count;
    logic                   host_bad, collide, idle_like, win, accept, underflow;

    always_comb begin
        push      = '0;
        push_data = '0;
        collide   = 1'b0;
        host_bad  = load_valid && (32'(load_lane) >= 32'(N));
        for (int i = 0; i < N; i++) begin
`ifdef OPERAND_STAGER_FEEDBACK_EN
            if (fb_valid[i]) begin
                push[i]      = 1'b1;
                push_data[i] = fb_data[i*DW +: DW];
                if (load_valid && (32'(load_lane) == 32'(i))) collide = 1'b1;
            end else if (load_valid && (32'(load_lane) == 32'(i))) begin
                push[i]      = 1'b1;
                push_data[i] = load_data;
            end
`else
            if (load_valid && (32'(load_lane) == 32'(i))) begin
                push[i]      = 1'b1;
                push_data[i] = load_data;
            end
`endif
        end
    end

`ifndef OPERAND_STAGER_FEEDBACK_EN
    logic unused_fb;
    assign unused_fb = ^{fb_valid, fb_data};
`endif

    // DRAIN behaves like IDLE for start so back-to-back streams need no gap state.
    assign idle_like = (state_q == IDLE) || (state_q == DRAIN);
    assign underflow = idle_like && start && (len != '0) && (|lane_short);
    assign accept    = idle_like && start && (len != '0) && !(|lane_short);

    // The accepting edge is stream cycle 0, so lane 0 pops on the same edge.
    assign win     = accept || (state_q == STREAM);
    assign c_sel   = accept ? '0 : cyc_q;
    assign len_sel = accept ? CW'(len) : CW'(len_q);

    always_comb begin
        err_set          = '0;
        err_set[ERR_OVF] = host_bad || (|ovf);
        err_set[ERR_UNF] = underflow;
        err_set[ERR_COL] = collide;
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane_short[g] = (count[g] < len);
        assign pop[g] = win && (c_sel >= CW'(g)) && (c_sel < CW'(g) + len_sel);

        stager_lane_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (push[g]),
            .push_data_i (push_data[g]),
            .pop_i       (pop[g]),
            .count_o     (count[g]),
            .full_o      (unused_full[g]),
            .empty_o     (unused_empty[g]),
            .ovf_o       (ovf[g]),
            .vld_o       (out_valid[g]),
            .data_o      (lane_data[g])
        );
    end

    assign out_data = lane_data;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            len_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_q   <= '0;
        end else begin
            done  <= 1'b0;
            err_q <= err_q | err_set;
            case (state_q)
                IDLE, DRAIN: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    if (start && (len == '0)) begin
                        state_q <= DRAIN;
                        done    <= 1'b1;
                    end else if (accept) begin
                        state_q <= STREAM;
                        busy    <= 1'b1;
                        len_q   <= len;
                        cyc_q   <= CW'(1);
                    end
                end
                STREAM: begin
                    if (cyc_q == CW'(len_q) + CW'(N - 1)) begin
                        state_q <= DRAIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_stager.sv
// Scoreboard bench for operand_stager (N=2, DEPTH=4): directed loads/starts, monitor pops expected lane data.
module tb_operand_stager;
    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
`ifdef OPERAND_STAGER_FEEDBACK_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_valid = 1'b0;
    logic [0:0]        load_lane = '0;
    logic signed [DW-1:0] load_data = '0;
    logic [N-1:0]      fb_valid = '0;
    logic [N*DW-1:0]   fb_data = '0;
    logic              start = 1'b0;
    logic [2:0]        len = '0;
    logic [N-1:0]      out_valid;
    logic [N*DW-1:0]   out_data;
    logic              busy, done;
    logic [2:0]        err;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] expq [N][$];

    operand_stager #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_lane(load_lane),
        .load_data(load_data), .fb_valid(fb_valid), .fb_data(fb_data),
        .start(start), .len(len), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_chk(input string tag, input logic [1:0] v, input logic b, input logic d);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
    endtask

    task automatic load(input int lane, input int data);
        load_valid = 1'b1;
        load_lane  = 1'(lane);
        load_data  = DW'(data);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < N; i++) expq[i].delete();
        rst = 1'b1;
    endtask

    // Monitor: every presented lane word must match the oldest expected word for that lane.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (out_valid[i]) begin
                if (expq[i].size() == 0) begin
                    chk($sformatf("lane%0d unexpected word", i), 32'(out_data[i*DW +: DW]), 32'hdead);
                end else begin
                    chk($sformatf("lane%0d data", i), 32'(out_data[i*DW +: DW]), 32'(expq[i].pop_front()));
                end
            end else if (out_data[i*DW +: DW] != '0) begin
                chk($sformatf("lane%0d idle data", i), 32'(out_data[i*DW +: DW]), 32'h0);
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        cyc_chk("reset", 2'b00, 1'b0, 1'b0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset err", 32'(err), 32'h0);
        rst = 1'b1;
        tick();

        // Basic wavefront, len=3
        load(0, 1); load(0, 2); load(0, 3);
        load(1, 4); load(1, 5); load(1, 6);
        start = 1'b1; len = 3'd3;
        expq[0].push_back(16'd1); expq[0].push_back(16'd2); expq[0].push_back(16'd3);
        expq[1].push_back(16'd4); expq[1].push_back(16'd5); expq[1].push_back(16'd6);
        tick(); start = 1'b0;
        cyc_chk("t1 c1", 2'b01, 1'b1, 1'b0); tick();
        cyc_chk("t1 c2", 2'b11, 1'b1, 1'b0); tick();
        cyc_chk("t1 c3", 2'b11, 1'b1, 1'b0); tick();
        cyc_chk("t1 c4", 2'b10, 1'b1, 1'b0); tick();
        cyc_chk("t1 c5", 2'b00, 1'b0, 1'b1); tick();
        cyc_chk("t1 c6", 2'b00, 1'b0, 1'b0);
        chk("t1 err", 32'(err), 32'h0);

        // Underflow then overflow
        load(0, 10); load(0, 11);
        start = 1'b1; len = 3'd3;
        tick(); start = 1'b0;
        cyc_chk("t2 unf c1", 2'b00, 1'b0, 1'b0);
        chk("t2 err unf", 32'(err), 32'b010);
        tick();
        cyc_chk("t2 unf c2", 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) load(1, 20 + k);
        chk("t2 err ovf", 32'(err), 32'b011);
        start = 1'b1; len = 3'd2;
        expq[0].push_back(16'd10); expq[0].push_back(16'd11);
        expq[1].push_back(16'd20); expq[1].push_back(16'd21);
        tick(); start = 1'b0;
        cyc_chk("t2 c1", 2'b01, 1'b1, 1'b0); tick();
        cyc_chk("t2 c2", 2'b11, 1'b1, 1'b0); tick();
        cyc_chk("t2 c3", 2'b10, 1'b1, 1'b0); tick();
        cyc_chk("t2 c4", 2'b00, 1'b0, 1'b1);

        // Host/feedback collision on lane1
        do_reset();
        load(0, 30); load(0, 31);
        load_valid = 1'b1; load_lane = 1'b1; load_data = 16'sd7;
        fb_valid = 2'b10; fb_data = {16'd9, 16'd0};
        tick();
        load_valid = 1'b0; fb_valid = 2'b00; fb_data = '0;
        chk("t3 err col", 32'(err), {29'd0, FB, 2'b00});
        start = 1'b1; len = 3'd2;
        tick(); start = 1'b0;
        cyc_chk("t3 single entry", 2'b00, 1'b0, 1'b0);
        chk("t3 err unf", 32'(err[1]), 32'h1);
        start = 1'b1; len = 3'd1;
        expq[0].push_back(16'd30);
        expq[1].push_back(FB ? 16'd9 : 16'd7);
        tick(); start = 1'b0;
        cyc_chk("t3 c1", 2'b01, 1'b1, 1'b0); tick();
        cyc_chk("t3 c2", 2'b10, 1'b1, 1'b0); tick();
        cyc_chk("t3 c3", 2'b00, 1'b0, 1'b1);

        // Back-to-back len=1 streams; start held high through the first stream
        do_reset();
        load(0, 40); load(0, 41); load(1, 50); load(1, 51);
        start = 1'b1; len = 3'd1;
        expq[0].push_back(16'd40); expq[1].push_back(16'd50);
        tick();
        cyc_chk("t4 c1", 2'b01, 1'b1, 1'b0); tick();
        cyc_chk("t4 c2", 2'b10, 1'b1, 1'b0); tick();
        cyc_chk("t4 c3", 2'b00, 1'b0, 1'b1);
        expq[0].push_back(16'd41); expq[1].push_back(16'd51);
        tick(); start = 1'b0;
        cyc_chk("t4 c4", 2'b01, 1'b1, 1'b0); tick();
        cyc_chk("t4 c5", 2'b10, 1'b1, 1'b0); tick();
        cyc_chk("t4 c6", 2'b00, 1'b0, 1'b1);
        chk("t4 err", 32'(err), 32'h0);

        // Reset in the middle of STREAM
        load(0, 60); load(0, 61); load(0, 62);
        load(1, 70); load(1, 71); load(1, 72);
        start = 1'b1; len = 3'd3;
        expq[0].push_back(16'd60); expq[0].push_back(16'd61); expq[0].push_back(16'd62);
        expq[1].push_back(16'd70); expq[1].push_back(16'd71); expq[1].push_back(16'd72);
        tick(); start = 1'b0;
        cyc_chk("t5 c1", 2'b01, 1'b1, 1'b0); tick();
        cyc_chk("t5 c2", 2'b11, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < N; i++) expq[i].delete();
        cyc_chk("t5 rst", 2'b00, 1'b0, 1'b0);
        chk("t5 rst out_data", out_data, 32'h0);
        chk("t5 rst err", 32'(err), 32'h0);
        rst = 1'b1; start = 1'b1; len = 3'd1;
        tick(); start = 1'b0;
        cyc_chk("t5 post", 2'b00, 1'b0, 1'b0);
        chk("t5 err unf", 32'(err), 32'b010);

        // len=0 start on empty FIFOs
        do_reset();
        start = 1'b1; len = 3'd0;
        tick(); start = 1'b0;
        cyc_chk("t6 c1", 2'b00, 1'b0, 1'b1); tick();
        cyc_chk("t6 c2", 2'b00, 1'b0, 1'b0);
        chk("t6 err", 32'(err), 32'h0);

        tick();
        chk("lane0 leftover", 32'(expq[0].size()), 32'h0);
        chk("lane1 leftover", 32'(expq[1].size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
